// File: rtl/vga_rect_fill_ctrl.sv
// Raster-order rectangle fill / screen clear sequencer for the 160x120 VGA pixel port.
// Optional build macro RECT_FILL_OUTLINE_EN adds an outline-only mode.
module vga_rect_fill_ctrl #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter logic [2:0]  CLR_COL  = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       clear,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] w,
  input  logic [6:0] h,
  input  logic [2:0] colour_in,
`ifdef RECT_FILL_OUTLINE_EN
  input  logic       outline,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);

  localparam int unsigned XW  = 8;
  localparam int unsigned YW  = 7;
  localparam int unsigned XEW = XW + 1;
  localparam int unsigned YEW = YW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t         state;
  logic [XW-1:0]  ox, sw, cx;
  logic [YW-1:0]  oy, sh, cy;
  logic [2:0]     col;
  logic [XEW-1:0] xe;
  logic [YEW-1:0] ye;

  // Clipped exclusive end coordinates; widened so x0+w and y0+h cannot wrap.
  logic [XEW-1:0] sum_x, xe_c;
  logic [YEW-1:0] sum_y, ye_c;
  logic           empty_c, last_x, last_y, plot_en_c;

  assign sum_x   = XEW'(ox) + XEW'(sw);
  assign sum_y   = YEW'(oy) + YEW'(sh);
  assign xe_c    = (sum_x > XEW'(SCREEN_W)) ? XEW'(SCREEN_W) : sum_x;
  assign ye_c    = (sum_y > YEW'(SCREEN_H)) ? YEW'(SCREEN_H) : sum_y;
  assign empty_c = (XEW'(ox) >= xe_c) || (YEW'(oy) >= ye_c);
  assign last_x  = (XEW'(cx) == xe - XEW'(1));
  assign last_y  = (YEW'(cy) == ye - YEW'(1));

`ifdef RECT_FILL_OUTLINE_EN
  logic ol;
  assign plot_en_c = !ol || (cx == ox) || last_x || (cy == oy) || last_y;
`else
  assign plot_en_c = 1'b1;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      ox     <= '0;
      oy     <= '0;
      sw     <= '0;
      sh     <= '0;
      col    <= '0;
      cx     <= '0;
      cy     <= '0;
      xe     <= '0;
      ye     <= '0;
`ifdef RECT_FILL_OUTLINE_EN
      ol     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          plot <= 1'b0;
          // Clear wins over start when both arrive together.
          if (clear) begin
            ox    <= '0;
            oy    <= '0;
            sw    <= XW'(SCREEN_W);
            sh    <= YW'(SCREEN_H);
            col   <= CLR_COL;
`ifdef RECT_FILL_OUTLINE_EN
            ol    <= 1'b0;
`endif
            busy  <= 1'b1;
            state <= LOAD;
          end else if (start) begin
            ox    <= x0;
            oy    <= y0;
            sw    <= w;
            sh    <= h;
            col   <= colour_in;
`ifdef RECT_FILL_OUTLINE_EN
            ol    <= outline;
`endif
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          xe    <= xe_c;
          ye    <= ye_c;
          cx    <= ox;
          cy    <= oy;
          state <= empty_c ? DONE : DRAW;
        end
        DRAW: begin
          x      <= cx;
          y      <= cy;
          colour <= col;
          plot   <= plot_en_c;
          if (last_x) begin
            cx <= ox;
            if (last_y) state <= DONE;
            else        cy    <= cy + YW'(1);
          end else begin
            cx <= cx + XW'(1);
          end
        end
        DONE: begin
          plot  <= 1'b0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill_ctrl.sv
// Scoreboard bench for vga_rect_fill_ctrl: expected pixels queued per request, compared as plotted.
module tb_vga_rect_fill_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, clear;
  logic [7:0] x0, w;
  logic [6:0] y0, h;
  logic [2:0] col_in;
`ifdef RECT_FILL_OUTLINE_EN
  logic       outline;
`endif
  logic       busy, done, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  vga_rect_fill_ctrl dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .start    (start),
    .clear    (clear),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .colour_in(col_in),
`ifdef RECT_FILL_OUTLINE_EN
    .outline  (outline),
`endif
    .busy     (busy),
    .done     (done),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  int          obs_cycles, obs_first, obs_busy_bad;
  logic        obs_done_after;

  // Reference model: clipped raster scan of the requested rectangle.
  task automatic push_rect(input int ax, input int ay, input int aw, input int ah,
                           input logic [2:0] c);
    int xe, ye;
    xe = (ax + aw > 160) ? 160 : ax + aw;
    ye = (ay + ah > 120) ? 120 : ay + ah;
    for (int yy = ay; yy < ye; yy++)
      for (int xx = ax; xx < xe; xx++)
        exp_q.push_back({8'(xx), 7'(yy), c});
  endtask

  // Issues one request and records plotted pixels and timing until done (bounded by limit).
  task automatic run_op(input logic s, input logic c, input int ax, input int ay,
                        input int aw, input int ah, input logic [2:0] cl,
                        input int limit, input int inj_at);
    obs_q.delete();
    obs_cycles = 0;
    obs_first = -1;
    obs_busy_bad = 0;
    @(negedge clk);
    start = s; clear = c;
    x0 = 8'(ax); y0 = 7'(ay); w = 8'(aw); h = 7'(ah); col_in = cl;
    do begin
      @(posedge clk);
      obs_cycles++;
      @(negedge clk);
      start = 1'b0; clear = 1'b0;
      if (obs_cycles == inj_at) begin
        start = 1'b1;
        x0 = 8'(ax + 3); y0 = 7'(ay + 2); w = 8'(aw + 5); h = 7'(ah + 1); col_in = ~cl;
      end
      if (plot) begin
        obs_q.push_back({x, y, colour});
        if (obs_first < 0) obs_first = obs_cycles;
      end
      if (!done && !busy) obs_busy_bad++;
      if (done && busy) obs_busy_bad++;
    end while (!done && obs_cycles < limit);
    start = 1'b0;
    @(negedge clk);
    obs_done_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; clear = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; col_in = '0;
`ifdef RECT_FILL_OUTLINE_EN
    outline = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({plot, busy, done, x, y, colour} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_state: got plot=%b busy=%b done=%b x=%0d y=%0d c=%0d, want all 0",
               plot, busy, done, x, y, colour);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_fill;
    logic [17:0] e, o;
    exp_q.delete();
    push_rect(10, 20, 2, 2, 3'd5);
    run_op(1'b1, 1'b0, 10, 20, 2, 2, 3'd5, 50, 0);
    n_cmp++;
    if (obs_cycles !== 7) begin n_err++; $display("FAIL basic_done_cycles: got %0d want 7", obs_cycles); end
    n_cmp++;
    if (obs_first !== 3) begin n_err++; $display("FAIL basic_first_plot: got %0d want 3", obs_first); end
    n_cmp++;
    if (obs_busy_bad !== 0) begin n_err++; $display("FAIL basic_busy: got %0d bad cycles want 0", obs_busy_bad); end
    n_cmp++;
    if (obs_done_after !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got done=%b after pulse want 0", obs_done_after); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL basic_count: got %0d plots want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL basic_pixel: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                 o[17:10], o[9:3], o[2:0], e[17:10], e[9:3], e[2:0]);
      end
    end
  endtask

  task automatic test_zero_size;
    run_op(1'b1, 1'b0, 30, 30, 0, 3, 3'd2, 20, 0);
    n_cmp++;
    if (obs_cycles !== 3 || obs_q.size() != 0) begin
      n_err++; $display("FAIL zero_w: got %0d cycles %0d plots want 3 cycles 0 plots", obs_cycles, obs_q.size());
    end
    run_op(1'b1, 1'b0, 30, 30, 4, 0, 3'd2, 20, 0);
    n_cmp++;
    if (obs_cycles !== 3 || obs_q.size() != 0) begin
      n_err++; $display("FAIL zero_h: got %0d cycles %0d plots want 3 cycles 0 plots", obs_cycles, obs_q.size());
    end
  endtask

  task automatic test_clip;
    logic [17:0] e, o;
    exp_q.delete();
    push_rect(158, 50, 4, 1, 3'd3);
    push_rect(5, 118, 1, 5, 3'd6);
    run_op(1'b1, 1'b0, 158, 50, 4, 1, 3'd3, 30, 0);
    n_cmp++;
    if (obs_cycles !== 5) begin n_err++; $display("FAIL clip_x_cycles: got %0d want 5", obs_cycles); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL clip_x_pixel: got none want pixel %0d", i); end
      else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL clip_x_pixel: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                   o[17:10], o[9:3], o[2:0], e[17:10], e[9:3], e[2:0]);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL clip_x_extra: got %0d extra plots want 0", obs_q.size()); end
    run_op(1'b1, 1'b0, 5, 118, 1, 5, 3'd6, 30, 0);
    n_cmp++;
    if (obs_cycles !== 5 || obs_q.size() != 2) begin
      n_err++; $display("FAIL clip_y: got %0d cycles %0d plots want 5 cycles 2 plots", obs_cycles, obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL clip_y_pixel: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                 o[17:10], o[9:3], o[2:0], e[17:10], e[9:3], e[2:0]);
      end
    end
    run_op(1'b1, 1'b0, 200, 10, 10, 2, 3'd1, 30, 0);
    n_cmp++;
    if (obs_cycles !== 3 || obs_q.size() != 0) begin
      n_err++; $display("FAIL clip_full: got %0d cycles %0d plots want 3 cycles 0 plots", obs_cycles, obs_q.size());
    end
  endtask

  task automatic test_clear_priority;
    logic [17:0] e, o;
    exp_q.delete();
    push_rect(0, 0, 160, 120, 3'd0);
    run_op(1'b1, 1'b1, 10, 20, 2, 2, 3'd5, 20000, 0);
    n_cmp++;
    if (obs_cycles !== 19203) begin n_err++; $display("FAIL clear_cycles: got %0d want 19203", obs_cycles); end
    n_cmp++;
    if (obs_q.size() != 19200) begin n_err++; $display("FAIL clear_count: got %0d plots want 19200", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL clear_pixel: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                 o[17:10], o[9:3], o[2:0], e[17:10], e[9:3], e[2:0]);
      end
    end
  endtask

  task automatic test_busy_ignore;
    logic [17:0] e, o;
    exp_q.delete();
    push_rect(30, 40, 4, 3, 3'd2);
    run_op(1'b1, 1'b0, 30, 40, 4, 3, 3'd2, 100, 4);
    n_cmp++;
    if (obs_cycles !== 15) begin n_err++; $display("FAIL busy_ign_cycles: got %0d want 15", obs_cycles); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL busy_ign_count: got %0d plots want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL busy_ign_pixel: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                 o[17:10], o[9:3], o[2:0], e[17:10], e[9:3], e[2:0]);
      end
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || plot !== 1'b0) begin
      n_err++; $display("FAIL busy_ign_idle: got busy=%b plot=%b want 0 0", busy, plot);
    end
  endtask

  task automatic test_reset_mid_draw;
    logic [17:0] e, o;
    int stray;
    @(negedge clk);
    start = 1'b1; x0 = 8'd0; y0 = 7'd0; w = 8'd20; h = 7'd20; col_in = 3'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({plot, busy, done, x, y} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_mid: got plot=%b busy=%b done=%b x=%0d y=%0d want all 0", plot, busy, done, x, y);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || plot || busy) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin n_err++; $display("FAIL reset_mid_stray: got %0d active cycles want 0", stray); end
    exp_q.delete();
    push_rect(50, 60, 3, 2, 3'd6);
    run_op(1'b1, 1'b0, 50, 60, 3, 2, 3'd6, 50, 0);
    n_cmp++;
    if (obs_cycles !== 9) begin n_err++; $display("FAIL reset_mid_next_cycles: got %0d want 9", obs_cycles); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL reset_mid_next_count: got %0d plots want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_mid_next_pixel: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                 o[17:10], o[9:3], o[2:0], e[17:10], e[9:3], e[2:0]);
      end
    end
  endtask

`ifdef RECT_FILL_OUTLINE_EN
  task automatic test_outline;
    logic [17:0] e, o;
    exp_q.delete();
    for (int yy = 50; yy < 53; yy++)
      for (int xx = 40; xx < 43; xx++)
        if (!(xx == 41 && yy == 51)) exp_q.push_back({8'(xx), 7'(yy), 3'd4});
    outline = 1'b1;
    run_op(1'b1, 1'b0, 40, 50, 3, 3, 3'd4, 50, 0);
    outline = 1'b0;
    n_cmp++;
    if (obs_cycles !== 12) begin n_err++; $display("FAIL outline_cycles: got %0d want 12", obs_cycles); end
    n_cmp++;
    if (obs_q.size() != 8) begin n_err++; $display("FAIL outline_count: got %0d plots want 8", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL outline_pixel: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                 o[17:10], o[9:3], o[2:0], e[17:10], e[9:3], e[2:0]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_fill();
    test_zero_size();
    test_clip();
    test_busy_ignore();
    test_clear_priority();
    test_reset_mid_draw();
`ifdef RECT_FILL_OUTLINE_EN
    test_outline();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
